guitar_hero_judge: RTL and testbench
====================================

GUITAR_HERO_JUDGE -- requirements
Module: guitar_hero_judge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, meaning: cycles a synchronized key must hold a new level before it is accepted (10 ms at 25 MHz).
REQ-002 clk  input  1  pixel clock (25 MHz), sole clock of the block.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  game enable level (SW[9]).
REQ-005 lane_key_n  input  3  raw active-low lane buttons (KEY[2:0]), asynchronous to clk.
REQ-006 note_in_zone  input  3  level from display stage: a note of lane i is inside the strike window.
REQ-007 note_missed  input  3  one-cycle pulse from display stage: a note of lane i left the window unhit.
REQ-008 note_clear  output  3  one-cycle pulse to display stage: remove the note of lane i that was hit.
REQ-009 score_bcd  output  16  score as four BCD digits, [3:0] = units, drives HEX0..HEX3 decoders.
REQ-010 streak_led  output  10  thermometer of current streak, bit k set when streak > k (LEDR).
REQ-011 playing  output  1  high while state is PLAY.

Function
REQ-012 Each lane_key_n bit SHALL pass a 2-flop synchronizer, then be inverted to active-high.
REQ-013 Per lane, a debounce counter SHALL reset on any synchronized level that equals the accepted level, and update the accepted level when the counter reaches DEBOUNCE_CYCLES-1 with the differing level still present.
REQ-014 A press event SHALL be a 0->1 transition of the accepted level; releases generate no event.
REQ-015 State machine: IDLE -> PLAY when start=1 (entry clears score and streak); PLAY -> IDLE when start=0 (score and streak held); no other states.
REQ-016 In IDLE, press events and note_missed SHALL be ignored and note_clear SHALL stay 0.
REQ-017 In PLAY, a press on lane i with note_in_zone[i]=1 in the same cycle SHALL be a hit; with note_in_zone[i]=0 it SHALL be a wrong press.
REQ-018 For each hit, note_clear[i] SHALL pulse for exactly one cycle, one cycle after the press event; score and streak SHALL update in that same cycle.
REQ-019 Streak counter: 8 bits, +1 per hit, saturates at 255.
REQ-020 Any wrong press or note_missed pulse in a cycle SHALL force streak to 0 in the update cycle, overriding that cycle's hits; hits in that cycle still score.
REQ-021 Simultaneous hits on several lanes in one cycle SHALL each score and each increment streak (max +3).
REQ-022 Points per hit: 1 (see REQ-027 for multiplier), summed over lanes, added as BCD with correct decimal carry.
REQ-023 Score SHALL saturate at 9999; an addition that would exceed 9999 yields 9999.
REQ-024 streak_led SHALL be combinational from the registered streak; streak >= 10 lights all ten LEDs.

Reset
REQ-025 On rst: state IDLE, score_bcd=0, streak=0, streak_led=0, note_clear=0, playing=0, synchronizers and accepted levels = released, debounce counters = 0; no press event is generated on reset release.
REQ-026 Reset asserted mid-game SHALL abort immediately; a pending note_clear pulse SHALL not appear.

Configuration
REQ-027 Macro GUITAR_HERO_JUDGE_MULT_EN: when defined, a hit scores 2 points if streak before the update is >= 10, else 1; when undefined, every hit scores 1 point and no multiplier logic is present.

Verification
REQ-028 DEBOUNCE_CYCLES=4; start=1; note_in_zone=001; hold lane_key_n[0]=0 -> note_clear=001 for one cycle at 2+4+1 cycles after the edge (±1), score_bcd=0x0001, streak_led=0x001.
REQ-029 Key bounce 0/1 alternating every 2 cycles for 20 cycles, then settled high -> no press event, score unchanged.
REQ-030 Score preloaded to 9998 via hits; same-cycle hits on lanes 0 and 2 -> score_bcd=0x9999 (saturated), note_clear=101, streak +2.
REQ-031 Streak 5; same cycle: hit on lane 1 and note_missed=100 -> score +1, streak=0, streak_led=0.
REQ-032 With GUITAR_HERO_JUDGE_MULT_EN, 12 consecutive hits -> score 0x0014 (10x1 + 2x2); without macro -> 0x0012.
REQ-033 start 1->0 -> score held, playing=0, presses ignored; start 0->1 -> score_bcd=0, streak=0; rst pulse during a hit cycle -> no note_clear, all outputs 0.

Source files
------------

// File: rtl/guitar_hero_judge.sv
// Rhythm-game judge: debounces three lane keys, scores BCD hits and tracks the streak.
// Define GUITAR_HERO_JUDGE_MULT_EN to score double points once the streak is 10 or more.
module guitar_hero_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  lane_key_n,
  input  logic [2:0]  note_in_zone,
  input  logic [2:0]  note_missed,
  output logic [2:0]  note_clear,
  output logic [15:0] score_bcd,
  output logic [9:0]  streak_led,
  output logic        playing
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t state_q, state_d;

  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    acc_q, acc_d, acc_prev_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    key_lvl, press, hit, clear_q, clear_d;
  logic          fault;
  logic [1:0]    hit_cnt;
  logic [3:0]    pts;
  logic [3:0]    carry;
  logic [4:0]    dsum;
  logic [15:0]   score_add;
  logic [8:0]    streak_inc;
  logic [7:0]    streak_q, streak_d, streak_add;
  logic [15:0]   score_q, score_d;

  assign key_lvl = ~sync2_q;
  // Press is the registered rising edge of the accepted level, so reset release never fires one.
  assign press   = acc_q & ~acc_prev_q;
  assign hit     = press & note_in_zone;
  assign fault   = (|(press & ~note_in_zone)) | (|note_missed);
  assign hit_cnt = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]);

  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (key_lvl[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_MAX) acc_d[i] = key_lvl[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef GUITAR_HERO_JUDGE_MULT_EN
  assign pts = (streak_q >= 8'd10) ? {1'b0, hit_cnt, 1'b0} : {2'b00, hit_cnt};
`else
  assign pts = {2'b00, hit_cnt};
`endif

  // Ripple decimal add; a carry out of the thousands digit saturates to 9999.
  always_comb begin
    carry     = pts;
    dsum      = '0;
    score_add = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      dsum = {1'b0, score_q[4*d +: 4]} + {1'b0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 4'd1;
      end else begin
        carry = 4'd0;
      end
      score_add[4*d +: 4] = dsum[3:0];
    end
    if (carry != 4'd0) score_add = 16'h9999;
  end

  assign streak_inc = {1'b0, streak_q} + {7'd0, hit_cnt};
  assign streak_add = streak_inc[8] ? 8'hFF : streak_inc[7:0];

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    streak_d = streak_q;
    clear_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PLAY;
          score_d  = '0;
          streak_d = '0;
        end
      end
      PLAY: begin
        if (!start) state_d = IDLE;
        clear_d  = hit;
        score_d  = score_add;
        streak_d = fault ? 8'd0 : streak_add;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_q      <= '0;
      acc_prev_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q    <= IDLE;
      score_q    <= '0;
      streak_q   <= '0;
      clear_q    <= '0;
    end else begin
      sync1_q    <= lane_key_n;
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      score_q    <= score_d;
      streak_q   <= streak_d;
      clear_q    <= clear_d;
    end
  end

  always_comb begin
    streak_led = '0;
    for (int unsigned k = 0; k < 10; k++) streak_led[k] = (streak_q > 8'(k));
  end

  assign note_clear = clear_q;
  assign score_bcd  = score_q;
  assign playing    = (state_q == PLAY);

endmodule

// File: tb/tb_guitar_hero_judge.sv
// Scoreboard bench for guitar_hero_judge with a 4-cycle debounce.
module tb_guitar_hero_judge;

`ifdef GUITAR_HERO_JUDGE_MULT_EN
  localparam bit MULT = 1'b1;
`else
  localparam bit MULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  lane_key_n, note_in_zone, note_missed;
  logic [2:0]  note_clear;
  logic [15:0] score_bcd;
  logic [9:0]  streak_led;
  logic        playing;

  guitar_hero_judge #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .lane_key_n(lane_key_n),
    .note_in_zone(note_in_zone), .note_missed(note_missed), .note_clear(note_clear),
    .score_bcd(score_bcd), .streak_led(streak_led), .playing(playing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  clr;
    logic [15:0] score;
    logic [9:0]  led;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_score, m_streak;
  bit   m_play;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [9:0] to_led(input int s);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[k] = (s > k);
    return r;
  endfunction

  task automatic m_apply(input logic [2:0] lanes, input logic [2:0] zone, input logic [2:0] missed);
    logic [2:0] h;
    int pp;
    if (!m_play) return;
    h  = lanes & zone;
    pp = (MULT && m_streak >= 10) ? 2 : 1;
    m_score = m_score + $countones(h) * pp;
    if (m_score > 9999) m_score = 9999;
    if ((|(lanes & ~zone)) || (|missed)) m_streak = 0;
    else begin
      m_streak = m_streak + $countones(h);
      if (m_streak > 255) m_streak = 255;
    end
    if (h != 3'b000) sb.push_back({h, to_bcd(m_score), to_led(m_streak)});
  endtask

  // Press lanes, pulse note_missed on the press-event cycle, then release and settle.
  task automatic hit(input logic [2:0] lanes, input logic [2:0] zone, input logic [2:0] missed);
    m_apply(lanes, zone, missed);
    note_in_zone = zone;
    lane_key_n   = ~lanes;
    repeat (6) @(posedge clk);
    #1 note_missed = missed;
    @(posedge clk);
    #1;
    note_missed  = '0;
    lane_key_n   = '1;
    note_in_zone = '0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (note_clear !== 3'b000) begin
      if (sb.size() == 0) chk("unexpected note_clear", {29'd0, note_clear}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb note_clear", {29'd0, note_clear}, {29'd0, e.clr});
        chk("sb score_bcd", {16'd0, score_bcd}, {16'd0, e.score});
        chk("sb streak_led", {22'd0, streak_led}, {22'd0, e.led});
      end
    end
  end

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; lane_key_n = '1; note_in_zone = '0; note_missed = '0;
    m_score = 0; m_streak = 0; m_play = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset note_clear", {29'd0, note_clear}, 32'd0);
    chk("reset score", {16'd0, score_bcd}, 32'd0);
    chk("reset streak_led", {22'd0, streak_led}, 32'd0);
    chk("reset playing", {31'd0, playing}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    hit(3'b001, 3'b001, 3'b100);
    chk("idle score", {16'd0, score_bcd}, 32'd0);
    chk("idle playing", {31'd0, playing}, 32'd0);

    start = 1'b1;
    @(posedge clk);
    #1;
    m_play = 1'b1; m_score = 0; m_streak = 0;
    chk("play entered", {31'd0, playing}, 32'd1);

    m_apply(3'b001, 3'b001, 3'b000);
    note_in_zone = 3'b001;
    lane_key_n   = 3'b110;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (note_clear !== 3'b000) lat = c - 1;
    end
    chk("press latency 6..8", {31'd0, (lat >= 6 && lat <= 8)}, 32'd1);
    @(posedge clk);
    #1;
    lane_key_n = '1; note_in_zone = '0;
    repeat (7) @(posedge clk);
    #1;

    note_in_zone = 3'b001;
    for (int i = 0; i < 10; i++) begin
      lane_key_n = (i % 2 == 0) ? 3'b110 : 3'b111;
      repeat (2) @(posedge clk);
      #1;
    end
    lane_key_n = '1;
    repeat (8) @(posedge clk);
    #1;
    note_in_zone = '0;
    chk("bounce score", {16'd0, score_bcd}, 32'h0001);

    for (int i = 0; i < 4; i++) hit(3'b001, 3'b001, 3'b000);
    chk("streak 5 led", {22'd0, streak_led}, 32'h01F);
    hit(3'b010, 3'b010, 3'b100);
    chk("miss+hit score", {16'd0, score_bcd}, 32'h0006);
    chk("miss+hit led", {22'd0, streak_led}, 32'd0);

    hit(3'b001, 3'b001, 3'b000);
    hit(3'b100, 3'b000, 3'b000);
    chk("wrong press led", {22'd0, streak_led}, 32'd0);
    chk("wrong press score", {16'd0, score_bcd}, 32'h0007);

    start = 1'b0;
    @(posedge clk);
    #1;
    m_play = 1'b0;
    chk("stop playing", {31'd0, playing}, 32'd0);
    hit(3'b001, 3'b001, 3'b000);
    chk("held score", {16'd0, score_bcd}, 32'h0007);

    start = 1'b1;
    @(posedge clk);
    #1;
    m_play = 1'b1; m_score = 0; m_streak = 0;
    chk("restart score", {16'd0, score_bcd}, 32'd0);
    chk("restart led", {22'd0, streak_led}, 32'd0);
    for (int i = 0; i < 12; i++) hit(3'b001, 3'b001, 3'b000);
    chk("12-hit score", {16'd0, score_bcd}, MULT ? 32'h0014 : 32'h0012);

    while (m_score < 9998) begin
      int rem, pp;
      rem = 9998 - m_score;
      pp  = (MULT && m_streak >= 10) ? 2 : 1;
      if (rem >= 3 * pp)  hit(3'b111, 3'b111, 3'b000);
      else if (rem >= pp) hit(3'b001, 3'b001, 3'b000);
      else                hit(3'b001, 3'b000, 3'b000);
    end
    hit(3'b010, 3'b000, 3'b000);
    chk("preload score", {16'd0, score_bcd}, 32'h9998);
    hit(3'b101, 3'b101, 3'b000);
    chk("saturated score", {16'd0, score_bcd}, 32'h9999);
    chk("saturated led", {22'd0, streak_led}, 32'h003);

    note_in_zone = 3'b001;
    lane_key_n   = 3'b110;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    m_play = 1'b0; m_score = 0; m_streak = 0;
    @(posedge clk);
    #1;
    chk("rst note_clear", {29'd0, note_clear}, 32'd0);
    chk("rst score", {16'd0, score_bcd}, 32'd0);
    chk("rst streak_led", {22'd0, streak_led}, 32'd0);
    chk("rst playing", {31'd0, playing}, 32'd0);
    lane_key_n = '1; note_in_zone = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post-rst score", {16'd0, score_bcd}, 32'd0);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
